// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and FSM state type for the LED frame serializer
package led_pkg;

  // GRB pixel layout: G in the top byte, then R, then B
  localparam int G_OFS = 16;
  localparam int R_OFS = 8;
  localparam int B_OFS = 0;
  localparam int CH_W = R_OFS - B_OFS;
  localparam int GRB_BITS = G_OFS + CH_W;

  localparam int DEF_NUM_LEDS = 64;
  localparam int CLK_PERIOD_NS = 10;
  localparam int LATCH_NS = 50_000;
  localparam int DEF_LATCH_CYCLES = LATCH_NS / CLK_PERIOD_NS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_PRIME_WAIT,
    ST_SHIFT,
    ST_LATCH
  } state_t;

endpackage

// File: rtl/pixel_prefetch_buf.sv
// rtl/pixel_prefetch_buf.sv - frame RAM read port plus one-entry prefetch holding register
module pixel_prefetch_buf #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rd_req,
  input  logic              rd_keep,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              consume,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] next_data,
  output logic              next_valid
);

  // keep_q rides alongside pix_rd_en; cap_q marks the cycle RAM data is valid
  logic keep_q;
  logic cap_q;

  // Issue reads, align the one-cycle RAM latency, and hold the prefetched pixel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_rd_en  <= 1'b0;
      pix_addr   <= '0;
      keep_q     <= 1'b0;
      cap_q      <= 1'b0;
      next_data  <= '0;
      next_valid <= 1'b0;
    end else begin
      pix_rd_en <= rd_req;
      keep_q    <= rd_req & rd_keep;
      cap_q     <= pix_rd_en & keep_q;
      if (rd_req) pix_addr <= rd_addr;
      if (cap_q) begin
        next_data  <= pix_data;
        next_valid <= 1'b1;
      end else if (consume) begin
        next_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/led_frame_serializer.sv
// rtl/led_frame_serializer.sv - reads a GRB frame from RAM and serializes it bit by bit for the LED transmitter
module led_frame_serializer
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int BITS_PER_LED = GRB_BITS,
  parameter int ADDR_W       = 6,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    frame_start,
  output logic                    frame_busy,
  output logic                    pix_rd_en,
  output logic [ADDR_W-1:0]       pix_addr,
  input  logic [BITS_PER_LED-1:0] pix_data,
  input  logic                    new_bit_rqst,
  output logic                    bit_to_transmit,
  output logic                    all_bits_shifted,
  output logic                    rqst_err
);

  localparam int MSB = BITS_PER_LED - 1;
  localparam int BCW = $clog2(BITS_PER_LED);
  localparam int LCW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  state_t                  state;
  logic [BITS_PER_LED-1:0] shift_reg;
  logic [BCW-1:0]          bit_cnt;
  logic [ADDR_W-1:0]       led_idx;
  logic [LCW-1:0]          latch_cnt;
  logic                    pending;

  logic                    fetch_req;
  logic                    fetch_keep;
  logic [ADDR_W-1:0]       fetch_addr;
  logic                    consume;
  logic [BITS_PER_LED-1:0] next_data;
  logic                    next_valid;

  logic                    last_pix;
  logic [ADDR_W:0]         nxt_fetch;
  logic                    pix_done_rqst;
  logic                    underrun;

  assign last_pix      = (led_idx == ADDR_W'(NUM_LEDS - 1));
  assign nxt_fetch     = {1'b0, led_idx} + (ADDR_W + 1)'(2);
  assign pix_done_rqst = (state == ST_SHIFT) && new_bit_rqst && (bit_cnt == '0) && !last_pix;
  assign underrun      = pix_done_rqst && !next_valid;

  pixel_prefetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (BITS_PER_LED)
  ) u_prefetch (
    .clk        (clk),
    .rstn       (rstn),
    .rd_req     (fetch_req),
    .rd_keep    (fetch_keep),
    .rd_addr    (fetch_addr),
    .consume    (consume),
    .pix_data   (pix_data),
    .pix_rd_en  (pix_rd_en),
    .pix_addr   (pix_addr),
    .next_data  (next_data),
    .next_valid (next_valid)
  );

  // Decide which RAM read to issue this cycle: prime read of pixel 0 or a prefetch
  always_comb begin
    fetch_req  = 1'b0;
    fetch_keep = 1'b0;
    fetch_addr = '0;
    consume    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start || pending) fetch_req = 1'b1;
      end
      ST_PRIME_WAIT: begin
        if (NUM_LEDS > 1) begin
          fetch_req  = 1'b1;
          fetch_keep = 1'b1;
          fetch_addr = ADDR_W'(1);
        end
      end
      ST_SHIFT: begin
        if (pix_done_rqst) begin
          consume = 1'b1;
          if (nxt_fetch < (ADDR_W + 1)'(NUM_LEDS)) begin
            fetch_req  = 1'b1;
            fetch_keep = 1'b1;
            fetch_addr = nxt_fetch[ADDR_W-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Frame FSM: prime, shift out MSB first, hold the latch gap, track pending starts and errors
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= ST_IDLE;
      frame_busy       <= 1'b0;
      bit_to_transmit  <= 1'b0;
      all_bits_shifted <= 1'b1;
      rqst_err         <= 1'b0;
      shift_reg        <= '0;
      bit_cnt          <= '0;
      led_idx          <= '0;
      latch_cnt        <= '0;
      pending          <= 1'b0;
    end else begin
      if (frame_start) rqst_err <= 1'b0;
      if (new_bit_rqst && (all_bits_shifted || underrun)) rqst_err <= 1'b1;
      if (frame_start && (state != ST_IDLE)) pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (frame_start || pending) begin
            state      <= ST_PRIME;
            frame_busy <= 1'b1;
            pending    <= 1'b0;
            led_idx    <= '0;
          end
        end
        ST_PRIME: state <= ST_PRIME_WAIT;
        ST_PRIME_WAIT: begin
          shift_reg        <= pix_data;
          bit_cnt          <= BCW'(MSB);
          bit_to_transmit  <= pix_data[MSB];
          all_bits_shifted <= 1'b0;
          state            <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (new_bit_rqst) begin
            if (bit_cnt != '0) begin
              shift_reg       <= shift_reg << 1;
              bit_cnt         <= bit_cnt - BCW'(1);
              bit_to_transmit <= shift_reg[MSB-1];
            end else if (!last_pix) begin
              shift_reg       <= next_data;
              bit_cnt         <= BCW'(MSB);
              led_idx         <= led_idx + ADDR_W'(1);
              bit_to_transmit <= next_data[MSB];
            end else begin
              all_bits_shifted <= 1'b1;
              latch_cnt        <= '0;
              state            <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          if (latch_cnt == LCW'(LATCH_CYCLES - 1)) begin
            state      <= ST_IDLE;
            frame_busy <= 1'b0;
          end else begin
            latch_cnt <= latch_cnt + LCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_serializer.sv
// tb/tb_led_frame_serializer.sv - directed self-checking bench for led_frame_serializer
module tb_led_frame_serializer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  fs = '0;
  logic [1:0]  rq = '0;
  logic [1:0]  busy, rd_en, bit_o, abs_o, err;
  logic [0:0]  addr_a;
  logic [1:0]  addr_b;
  logic [23:0] pd_a = '0;
  logic [23:0] pd_b = '0;
  logic [23:0] ram_a [2];
  logic [23:0] ram_b [4];
  int          checks = 0;
  int          errors = 0;
  int          gap_cnt [2] = '{100, 100};
  logic [71:0] s;
  int          n;

  always #5 clk = ~clk;

  led_frame_serializer #(
    .NUM_LEDS(2), .BITS_PER_LED(24), .ADDR_W(1), .LATCH_CYCLES(100)
  ) dut_a (
    .clk(clk), .rstn(rstn), .frame_start(fs[0]), .frame_busy(busy[0]),
    .pix_rd_en(rd_en[0]), .pix_addr(addr_a), .pix_data(pd_a),
    .new_bit_rqst(rq[0]), .bit_to_transmit(bit_o[0]),
    .all_bits_shifted(abs_o[0]), .rqst_err(err[0])
  );

  led_frame_serializer #(
    .NUM_LEDS(3), .BITS_PER_LED(24), .ADDR_W(2), .LATCH_CYCLES(100)
  ) dut_b (
    .clk(clk), .rstn(rstn), .frame_start(fs[1]), .frame_busy(busy[1]),
    .pix_rd_en(rd_en[1]), .pix_addr(addr_b), .pix_data(pd_b),
    .new_bit_rqst(rq[1]), .bit_to_transmit(bit_o[1]),
    .all_bits_shifted(abs_o[1]), .rqst_err(err[1])
  );

  // synchronous frame RAMs, data valid one cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en[0]) pd_a <= ram_a[addr_a];
    if (rd_en[1]) pd_b <= ram_b[addr_b];
  end

  // transmitter requests must be at least 4 cycles apart
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rq[i]) begin
        if (gap_cnt[i] < 3) $error("request spacing below 4 cycles on dut %0d", i);
        gap_cnt[i] <= 0;
      end else if (gap_cnt[i] < 1000) begin
        gap_cnt[i] <= gap_cnt[i] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  task automatic start_frame(input int d);
    fs[d] = 1'b1;
    step(1);
    fs[d] = 1'b0;
    check("accept_busy", busy[d], 1'b1);
    step(1);
    check("prime_abs_high", abs_o[d], 1'b1);
    step(1);
    check("start_lat3_abs_low", abs_o[d], 1'b0);
  endtask

  task automatic play(input int d, input int nbits, input int gap, input bit fs_last,
                      output logic [71:0] stream);
    stream = '0;
    for (int i = 0; i < nbits; i++) begin
      stream = {stream[70:0], bit_o[d]};
      rq[d] = 1'b1;
      if (fs_last && (i == nbits - 1)) fs[d] = 1'b1;
      step(1);
      rq[d] = 1'b0;
      fs[d] = 1'b0;
      if (i < nbits - 1) step(gap - 1);
    end
  endtask

  task automatic latch_len(input int d, input bit pulse_fs, output int cnt);
    cnt = 0;
    while (busy[d] && cnt < 1000) begin
      fs[d] = pulse_fs && (cnt == 20);
      step(1);
      cnt++;
    end
    fs[d] = 1'b0;
  endtask

  initial begin
    ram_a = '{24'hFF0000, 24'h000001};
    ram_b = '{24'hA5A5A5, 24'h5A5A5A, 24'hC3C3C3, 24'h000000};
    step(3);
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", busy[d], 1'b0);
      check("rst_rd_en", rd_en[d], 1'b0);
      check("rst_bit", bit_o[d], 1'b0);
      check("rst_abs", abs_o[d], 1'b1);
      check("rst_err", err[d], 1'b0);
    end
    check("rst_addr_a", addr_a, 1'b0);
    check("rst_addr_b", addr_b, 2'd0);
    rstn = 1'b1;
    step(2);

    // single 2-pixel frame at 120-cycle request spacing
    start_frame(0);
    check("first_bit", bit_o[0], 1'b1);
    play(0, 48, 120, 1'b0, s);
    check("frame1_stream", s[47:0], 48'hFF0000_000001);
    check("abs_after_last", abs_o[0], 1'b1);

    // latch length with a frame_start arriving mid-latch
    ram_a = '{24'h7FFFFF, 24'hFFFFFF};
    latch_len(0, 1'b1, n);
    check("latch_len", n, 100);
    step(2);
    check("pend_abs_high", abs_o[0], 1'b1);
    step(1);
    check("pend_abs_low_3", abs_o[0], 1'b0);
    check("pend_busy", busy[0], 1'b1);

    // reset at bit 30 of 48
    play(0, 30, 4, 1'b0, s);
    check("pre_reset_bits", s[29:0], 30'h1FFFFFFF);
    check("bit30_value", bit_o[0], 1'b1);
    rstn = 1'b0;
    #1;
    check("mid_rst_abs", abs_o[0], 1'b1);
    check("mid_rst_bit", bit_o[0], 1'b0);
    check("mid_rst_busy", busy[0], 1'b0);
    step(1);
    rstn = 1'b1;
    step(2);
    check("post_rst_idle", busy[0], 1'b0);
    start_frame(0);
    check("restart_bit23", bit_o[0], 1'b0);

    // frame_start together with the final request
    play(0, 48, 4, 1'b1, s);
    check("frame3_stream", s[47:0], 48'h7FFFFF_FFFFFF);
    check("coll_abs_high", abs_o[0], 1'b1);
    latch_len(0, 1'b0, n);
    check("coll_latch_len", n, 100);
    step(2);
    check("coll_abs_high2", abs_o[0], 1'b1);
    step(1);
    check("coll_restart", abs_o[0], 1'b0);

    // three pixels at minimum request spacing
    start_frame(1);
    play(1, 72, 4, 1'b0, s);
    check("boundary_stream", s, 72'hA5A5A5_5A5A5A_C3C3C3);
    check("b_abs_after_last", abs_o[1], 1'b1);
    latch_len(1, 1'b0, n);
    check("b_latch_len", n, 100);

    // spurious request in IDLE
    rq[1] = 1'b1;
    step(1);
    rq[1] = 1'b0;
    check("spur_err", err[1], 1'b1);
    check("spur_busy", busy[1], 1'b0);
    check("spur_abs", abs_o[1], 1'b1);
    check("spur_rd_en", rd_en[1], 1'b0);
    step(5);
    check("spur_still_idle", busy[1], 1'b0);
    check("spur_err_sticky", err[1], 1'b1);
    fs[1] = 1'b1;
    step(1);
    fs[1] = 1'b0;
    check("err_cleared", err[1], 1'b0);
    check("err_clr_busy", busy[1], 1'b1);
    step(2);
    check("err_clr_abs_low", abs_o[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_frame_serializer.md
Name: led_frame_serializer

Overview:
- Upstream feeder of the LED-stripe bit transmitter.
- On a frame trigger from game logic, it reads NUM_LEDS 24-bit GRB pixels from the synchronous frame RAM. It serializes them MSB-first, one bit per transmitter request.
- It signals end-of-frame with all_bits_shifted and enforces a minimum latch/idle time before accepting the next frame.
- A double-buffered pixel path ensures the next bit is always valid when the transmitter asks for it.

Parameters:
- NUM_LEDS, 64, number of pixels per frame.
- BITS_PER_LED, 24, bits per pixel ({G,R,B}, MSB first).
- ADDR_W, 6, frame RAM address width; must satisfy 2**ADDR_W >= NUM_LEDS.
- LATCH_CYCLES, 5000, minimum clk cycles all_bits_shifted stays high after a frame (50 us at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rstn  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse requesting a frame transmission.
- frame_busy  out  1  high from frame acceptance until latch time expires.
- pix_rd_en  out  1  frame RAM read strobe.
- pix_addr  out  ADDR_W  frame RAM read address.
- pix_data  in  BITS_PER_LED  frame RAM data, valid exactly 1 cycle after pix_rd_en.
- new_bit_rqst  in  1  single-cycle pulse from transmitter; consumes current bit.
- bit_to_transmit  out  1  current bit; stable between requests.
- all_bits_shifted  out  1  high = no data pending (idle/latch); low = frame bits available.
- rqst_err  out  1  sticky; set by new_bit_rqst while all_bits_shifted high; cleared by frame_start.

Behaviour:
- Reset (async, rstn=0) values: state IDLE, frame_busy=0, pix_rd_en=0, pix_addr=0, bit_to_transmit=0, all_bits_shifted=1, rqst_err=0. Internal state is cleared: counters, next_valid, pending.
- FSM states: IDLE, PRIME, PRIME_WAIT, SHIFT, LATCH.
- IDLE:
  - frame_start (or pending flag) -> PRIME.
  - Assert pix_rd_en with pix_addr=0.
  - frame_busy=1.
- PRIME: wait 1 cycle for RAM.
- PRIME_WAIT:
  - Capture pix_data into shift_reg and set bit_cnt=BITS_PER_LED-1.
  - Immediately issue a prefetch read of addr 1 if NUM_LEDS>1.
  - -> SHIFT, and drop all_bits_shifted to 0 in the same cycle.
  - Total latency from frame_start to all_bits_shifted=0: 3 cycles.
- Prefetch:
  - One cycle after a prefetch read, pix_data is captured into next_reg and next_valid=1.
  - pix_addr holds the last requested address.
- SHIFT:
  - bit_to_transmit = shift_reg[MSB] (registered).
  - On new_bit_rqst with bit_cnt>0: shift left, bit_cnt--.
  - On new_bit_rqst with bit_cnt==0 and a pixel remaining:
    - Load shift_reg from next_reg and reset bit_cnt.
    - Increment led_idx.
    - Issue the next prefetch if led_idx+1 < NUM_LEDS.
  - new_bit_rqst arriving while next_valid=0 is not possible in spec. Minimum request spacing is 4 cycles; the transmitter bit period is at least 120 cycles. The bench asserts this.
  - On new_bit_rqst at the last bit of the last pixel: all_bits_shifted=1 next cycle, latch counter cleared -> LATCH.
- LATCH:
  - Count to LATCH_CYCLES-1, then -> IDLE and clear frame_busy.
  - The frame_start pending flag is serviced on entry to IDLE.
- frame_start while busy:
  - Sets a single pending flag; multiple pulses collapse into one.
  - Never aborts the current frame.
- new_bit_rqst in IDLE/PRIME/PRIME_WAIT/LATCH: ignored for data, sets rqst_err.
- frame_start and the last new_bit_rqst in the same cycle: the request completes the frame and frame_start becomes pending.
- Widths:
  - bit_cnt is clog2(BITS_PER_LED) bits.
  - led_idx is ADDR_W bits; no wrap is possible, because termination uses led_idx==NUM_LEDS-1.
  - The latch counter is clog2(LATCH_CYCLES) bits.
- Reset mid-frame: all outputs return to reset values asynchronously; the pending flag is lost.

Decomposition:
- Shared package (led_pkg) holds: the default LED count, BITS_PER_LED=24, GRB field offsets, the 100 MHz clock-period constant, the latch-cycle constant, and the FSM state enum.
- One natural sub-module, pixel_prefetch_buf: a one-entry holding register with valid flag, RAM read-latency alignment and load/consume handshake.
- The FSM and shift register stay in the top level.

Test Plan:
- Single frame: NUM_LEDS=2, RAM={24'hFF0000, 24'h000001}; frame_start; requests every 120 cycles.
  - Expect 48 bits: 8 ones, 39 zeros, final 1.
  - all_bits_shifted low 3 cycles after frame_start, high 1 cycle after the 48th request.
- Latch timing, LATCH_CYCLES=100: after the last bit, frame_busy stays high exactly 100 cycles.
  - A second frame_start during latch is pending; all_bits_shifted falls again 3 cycles after IDLE entry.
- Pixel boundary, minimum spacing: requests every 4 cycles over 3 LEDs {A5A5A5, 5A5A5A, C3C3C3}.
  - Serial stream matches MSB-first concatenation with no duplicated or dropped bits.
- Spurious requests: new_bit_rqst in IDLE -> rqst_err=1 and no state change; next frame_start clears rqst_err.
- Reset mid-frame: deassert rstn at bit 30 of 48.
  - all_bits_shifted=1, bit_to_transmit=0, frame_busy=0 immediately.
  - A new frame after reset restarts at pixel 0 bit 23.
- Collision: frame_start in the same cycle as the final request.
  - Frame ends normally, latch runs fully, then the second frame starts without another pulse.
